// File: rtl/ppwm_pkg.sv
// Shared types and default geometry for the PWM sequencer and its duty memory.
package ppwm_pkg;
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_DEPTH = 32;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_seq_if.sv
// Read port between the PWM sequencer (master) and the duty-word memory (slave).
interface pwm_seq_if
  import ppwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                     programmed_i;
  logic [WIDTH-1:0]         data_i;
  logic [$clog2(DEPTH)-1:0] addr_o;

  modport master (input programmed_i, input data_i, output addr_o);
  modport slave  (output programmed_i, output data_i, input addr_o);
endinterface

// File: rtl/tick_gen.sv
// Prescaler: tick_o pulses on the last of every PRESCALE cycles while clr_i is low.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_seq.sv
// Steps through a duty-word memory, playing REPEAT PWM periods per entry with a
// one-cycle load gap between entries.
module pwm_seq
  import ppwm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PRESCALE = 1,
  parameter int REPEAT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_seq_if.master  mem,
  output logic       pwm_o,
  output logic       step_o,
  output logic       active_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = cntWidth(REPEAT);
  localparam logic [WIDTH-1:0] PHASE_MAX = '1;
  localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [RW-1:0]    REP_LAST  = RW'(REPEAT - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic             tick, tickClr;

  // Prescaler restarts at every StRun entry so the first tick lands PRESCALE cycles in.
  assign tickClr = (state_q != StRun) || !mem.programmed_i;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tickClr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    duty_d  = duty_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    step_o  = 1'b0;
    case (state_q)
      StIdle: begin
        addr_d  = '0;
        phase_d = '0;
        rep_d   = '0;
        if (mem.programmed_i) state_d = StLoad;
      end
      StLoad: begin
        duty_d  = mem.data_i;
        state_d = StRun;
      end
      StRun: begin
        if (tick) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == PHASE_MAX) begin
            if (rep_q == REP_LAST) begin
              rep_d   = '0;
              addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
              step_o  = rst_n;
              state_d = StLoad;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
        phase_d = '0;
        rep_d   = '0;
      end
    endcase
    // Losing the programmed flag aborts the entry and wins over any period-end advance.
    if (state_q != StIdle && !mem.programmed_i) begin
      state_d = StIdle;
      addr_d  = '0;
      phase_d = '0;
      rep_d   = '0;
      step_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      duty_q  <= '0;
      phase_q <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      duty_q  <= duty_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
    end
  end

  assign mem.addr_o = addr_q;
  assign pwm_o      = (state_q == StRun) && (phase_q < duty_q);
  assign active_o   = (state_q == StLoad) || (state_q == StRun);
endmodule

// File: doc/pwm_seq.md
PWM_SEQ -- requirements
Module: pwm_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 6, the duty-word width, equal to the memory word width.
REQ-002 SHALL have parameter DEPTH, default 32, the number of memory entries stepped through.
REQ-003 SHALL have parameter PRESCALE, default 1, the clock cycles per PWM tick (>=1).
REQ-004 SHALL have parameter REPEAT, default 1, the PWM periods played per entry (>=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-007 SHALL have port programmed_i, input, 1 bit: memory-programmed flag from the upstream memory; acts as run enable.
REQ-008 SHALL have port data_i, input, WIDTH bits: duty word read combinationally from the memory at addr_o.
REQ-009 SHALL have port addr_o, output, $clog2(DEPTH) bits: the memory read address (current entry).
REQ-010 SHALL have port pwm_o, output, 1 bit: the PWM waveform.
REQ-011 SHALL have port step_o, output, 1 bit: a one-cycle pulse when addr_o advances.
REQ-012 SHALL have port active_o, output, 1 bit: high while in StLoad or StRun.

Function
REQ-013 SHALL implement FSM states StIdle, StLoad and StRun.
REQ-014 StIdle: addr_o=0, phase, tick and repeat counters=0, pwm_o=0; on programmed_i=1 -> StLoad.
REQ-015 StLoad (exactly 1 cycle): duty_q <= data_i; pwm_o=0; -> StRun.
REQ-016 StRun: the prescaler issues a tick every PRESCALE cycles, with the first tick PRESCALE cycles after StRun entry; the phase counter (WIDTH bits, 0..2^WIDTH-1) increments on each tick and wraps to 0.
REQ-017 StRun: pwm_o = (phase < duty_q), unsigned compare from registered state only; duty 0 -> constant low; duty 2^WIDTH-1 -> high 2^WIDTH-1 of 2^WIDTH ticks.
REQ-018 Period end (tick with phase=2^WIDTH-1) with repeat count < REPEAT-1: repeat count +1; stay in StRun; duty_q unchanged.
REQ-019 Period end with repeat count = REPEAT-1: repeat count <= 0; addr_o <= addr_o+1, wrapping DEPTH-1 -> 0; step_o=1 that cycle; -> StLoad.
REQ-020 Entry duration SHALL be REPEAT*PRESCALE*2^WIDTH + 1 cycles (one StLoad gap per entry, pwm_o low during the gap).
REQ-021 programmed_i=0 in StLoad or StRun -> StIdle at the next edge, with all counters cleared; takes priority over period-end advance; step_o SHALL stay 0.
REQ-022 Latency: programmed_i sampled high at edge t -> StLoad after t, StRun after t+1; pwm_o high from edge t+1 if duty>0.
REQ-023 Illegal state encoding -> StIdle.

Reset
REQ-024 rst_n=0 at a clock edge -> StIdle, addr_o=0, duty_q=0, all counters 0; pwm_o=0, step_o=0, active_o=0; a reset mid-period SHALL abort the period with no step_o.

Structure
REQ-025 Package ppwm_pkg SHALL hold the state_e typedef and default WIDTH/DEPTH constants, shared with the memory block.
REQ-026 Prescaler SHALL be sub-module tick_gen (ports clk, rst_n, clr_i, tick_o; parameter PRESCALE); pwm_seq instantiates it.

Verification
REQ-027 Reset with programmed_i=1 held -> pwm_o=0, addr_o=0, active_o=0 during reset; StLoad on the first cycle after release.
REQ-028 Defaults, mem[0]=32, mem[1]=0 -> pwm_o high 32 cycles, low 32, low 1 (StLoad); step_o pulse; addr_o=1; then 64 low cycles.
REQ-029 mem[k]=63 -> pwm_o high 63 of each 65-cycle entry; mem[k]=0 -> never high.
REQ-030 Run 32 entries -> addr_o 31 -> 0 wrap with step_o pulse; sequence repeats identically.
REQ-031 programmed_i dropped at phase 10 of entry 5 -> pwm_o=0, addr_o=0, step_o stays 0 from the next edge; re-assert restarts at entry 0.
REQ-032 PRESCALE=3, REPEAT=2, mem[0]=16 -> each period high 48 / low 144 cycles; step_o 384 cycles after StRun entry; entry length 385.
